// File: rtl/crop_window_pkg.sv
// Shared constants and state encoding for the crop-window stage and its pixel counter.
package crop_window_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned PixW       = 10;
  localparam int unsigned CoordW     = 16;

  typedef enum logic [1:0] {
    StIdle,
    StWaitWin,
    StCrop,
    StDone
  } crop_state_e;

endpackage

// File: rtl/crop_window_frame_pos_counter.sv
// Valid-driven raster position counter: reports the coordinate of the pixel presented this
// cycle and strobes frame start when that pixel is (0,0).
module frame_pos_counter
  import crop_window_pkg::*;
#(
  parameter int unsigned HActive = DefHActive,
  parameter int unsigned VActive = DefVActive
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              dval_i,
  output logic [CoordW-1:0] x_o,
  output logic [CoordW-1:0] y_o,
  output logic              frame_start_o
);

  logic [CoordW-1:0] x_q, x_d, y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (dval_i) begin
      if (x_q == CoordW'(HActive - 1)) begin
        x_d = '0;
        y_d = (y_q == CoordW'(VActive - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o           = x_q;
  assign y_o           = y_q;
  assign frame_start_o = dval_i && (x_q == '0) && (y_q == '0);

endmodule

// File: rtl/crop_window.sv
// Forwards the pixels of a fixed-size window anchored at the row detected in the previous
// frame, as a compacted stream with in-window coordinates and an end-of-crop pulse.
module crop_window
  import crop_window_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned X_START  = 160,
  parameter int unsigned CROP_W   = 320,
  parameter int unsigned Y_OFFSET = 0,
  parameter int unsigned CROP_H   = 240
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDVAL,
  input  logic [PixW-1:0]   iDATA,
  input  logic [CoordW-1:0] iYSTART,
  output logic              oDVAL,
  output logic [PixW-1:0]   oDATA,
  output logic [CoordW-1:0] oCX,
  output logic [CoordW-1:0] oCY,
  output logic              oFRAME_DONE,
  output logic              oNO_MARK,
  output logic              oBUSY
);

  localparam int unsigned XLast = X_START + CROP_W - 1;

  logic [CoordW-1:0] pix_x, pix_y;
  logic              frame_start;

  frame_pos_counter #(
    .HActive(H_ACTIVE),
    .VActive(V_ACTIVE)
  ) u_pos (
    .clk_i        (iCLK),
    .rst_ni       (iRST),
    .dval_i       (iDVAL),
    .x_o          (pix_x),
    .y_o          (pix_y),
    .frame_start_o(frame_start)
  );

  crop_state_e state_q, state_d;
  logic [16:0] y0_q, y0_d, yend_q, yend_d;
  logic [16:0] fs_y0, fs_sum, fs_yend, pix_y17;
  logic        in_cols, emit, last_pix, no_mark;

  logic              dval_q, frame_done_q, no_mark_q;
  logic [PixW-1:0]   data_q;
  logic [CoordW-1:0] cx_q, cy_q;

  // Window bounds for a frame starting now, in 17 bits so large marks cannot wrap.
  assign fs_y0   = {1'b0, iYSTART} + 17'(Y_OFFSET);
  assign fs_sum  = fs_y0 + 17'(CROP_H);
  assign fs_yend = ((fs_sum > 17'(V_ACTIVE)) ? 17'(V_ACTIVE) : fs_sum) - 17'd1;
  assign pix_y17 = {1'b0, pix_y};
  assign in_cols = (pix_x >= CoordW'(X_START)) && (pix_x <= CoordW'(XLast));

  // Frame start is resolved first so the same pixel is then judged against the new window.
  always_comb begin
    state_d  = state_q;
    y0_d     = y0_q;
    yend_d   = yend_q;
    no_mark  = 1'b0;
    emit     = 1'b0;
    last_pix = 1'b0;
    if (frame_start) begin
      if ((iYSTART == '0) || (fs_y0 >= 17'(V_ACTIVE))) begin
        no_mark = 1'b1;
        state_d = StDone;
      end else begin
        y0_d    = fs_y0;
        yend_d  = fs_yend;
        state_d = StWaitWin;
      end
    end
    if (iDVAL) begin
      if ((state_d == StWaitWin) && (pix_y17 == y0_d)) begin
        state_d = StCrop;
      end
      if ((state_d == StCrop) && in_cols) begin
        emit = 1'b1;
        if ((pix_x == CoordW'(XLast)) && (pix_y17 == yend_d)) begin
          last_pix = 1'b1;
          state_d  = StDone;
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q      <= StIdle;
      y0_q         <= '0;
      yend_q       <= '0;
      dval_q       <= 1'b0;
      frame_done_q <= 1'b0;
      no_mark_q    <= 1'b0;
      data_q       <= '0;
      cx_q         <= '0;
      cy_q         <= '0;
    end else begin
      state_q      <= state_d;
      y0_q         <= y0_d;
      yend_q       <= yend_d;
      dval_q       <= emit;
      frame_done_q <= last_pix;
      no_mark_q    <= no_mark;
      if (emit) begin
        data_q <= iDATA;
        cx_q   <= pix_x - CoordW'(X_START);
        cy_q   <= pix_y - y0_d[CoordW-1:0];
      end
    end
  end

  assign oDVAL       = dval_q;
  assign oDATA       = data_q;
  assign oCX         = cx_q;
  assign oCY         = cy_q;
  assign oFRAME_DONE = frame_done_q;
  assign oNO_MARK    = no_mark_q;
  assign oBUSY       = (state_q == StWaitWin) || (state_q == StCrop);

endmodule

// File: tb/tb_crop_window.sv
// Randomised scoreboard bench for crop_window on a scaled-down raster.
module tb_crop_window;

  localparam int H    = 32;
  localparam int V    = 24;
  localparam int XS   = 8;
  localparam int CW   = 16;
  localparam int YOFF = 1;
  localparam int CH   = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dval = 1'b0;
  logic [9:0]  data = '0;
  logic [15:0] ystart = '0;
  logic        o_dval, o_frame_done, o_no_mark, o_busy;
  logic [9:0]  o_data;
  logic [15:0] o_cx, o_cy;

  crop_window #(
    .H_ACTIVE(H), .V_ACTIVE(V), .X_START(XS), .CROP_W(CW), .Y_OFFSET(YOFF), .CROP_H(CH)
  ) dut (
    .iCLK       (clk),
    .iRST       (rst_n),
    .iDVAL      (dval),
    .iDATA      (data),
    .iYSTART    (ystart),
    .oDVAL      (o_dval),
    .oDATA      (o_data),
    .oCX        (o_cx),
    .oCY        (o_cy),
    .oFRAME_DONE(o_frame_done),
    .oNO_MARK   (o_no_mark),
    .oBUSY      (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int cx;
    int cy;
    bit done;
    int stamp;
  } exp_t;

  exp_t exp_q[$];
  int   nm_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_done_cnt = 0;
  int   got_done_cnt = 0;
  bit   busy_exp = 1'b0;
  bit   mon_en = 1'b0;

  // Reference window of the frame in progress.
  bit   m_active = 1'b0;
  bit   m_done = 1'b0;
  int   m_y0 = 0;
  int   m_yend = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", o_busy, busy_exp);
      if (o_dval) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", o_dval, 0);
        end else begin
          e = exp_q.pop_front();
          check("data", o_data, e.data);
          check("cx", o_cx, e.cx);
          check("cy", o_cy, e.cy);
          check("frame_done", o_frame_done, e.done);
          check("latency", cyc, e.stamp);
          if (o_frame_done) got_done_cnt++;
        end
      end else begin
        check("stray_frame_done", o_frame_done, 0);
      end
      if (o_no_mark) begin
        if (nm_q.size() == 0) check("unexpected_no_mark", o_no_mark, 0);
        else check("no_mark_time", cyc, nm_q.pop_front());
      end
    end
  end

  // One clock of stimulus; expectations are derived from the frame rules, not DUT state.
  task automatic drive(input bit dv, input int x, input int y, input int d, input int ys);
    bit   busy_nxt;
    exp_t n;
    dval     = dv;
    data     = 10'(d);
    ystart   = 16'(ys);
    busy_nxt = busy_exp;
    if (dv) begin
      if (x == 0 && y == 0) begin
        m_y0     = ys + YOFF;
        m_active = (ys != 0) && (m_y0 < V);
        m_done   = 1'b0;
        if (!m_active) nm_q.push_back(cyc + 1);
        else m_yend = ((m_y0 + CH < V) ? m_y0 + CH : V) - 1;
        busy_nxt = m_active;
      end
      if (m_active && !m_done && y >= m_y0 && y <= m_yend && x >= XS && x < XS + CW) begin
        n.data  = d & 10'h3ff;
        n.cx    = x - XS;
        n.cy    = y - m_y0;
        n.done  = (x == XS + CW - 1) && (y == m_yend);
        n.stamp = cyc + 1;
        exp_q.push_back(n);
        if (n.done) begin
          exp_done_cnt++;
          m_done   = 1'b1;
          busy_nxt = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    busy_exp = busy_nxt;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_dval"}, o_dval, 0);
    check({name, "_data"}, o_data, 0);
    check({name, "_cx"}, o_cx, 0);
    check({name, "_cy"}, o_cy, 0);
    check({name, "_frame_done"}, o_frame_done, 0);
    check({name, "_no_mark"}, o_no_mark, 0);
    check({name, "_busy"}, o_busy, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    dval  = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    check("queue_at_reset", exp_q.size(), 0);
    exp_q.delete();
    m_active = 1'b0;
    m_done   = 1'b0;
    busy_exp = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random idle gaps.
  task automatic run_frame(input int ys_a, input int ys_b, input int chg_row, input int mode,
                           input int abort_row, input bit data_is_x);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        int ys;
        int d;
        ys = (y >= chg_row) ? ys_b : ys_a;
        if (y == abort_row && x == XS + 3) begin
          do_reset();
          return;
        end
        d = data_is_x ? x : int'($urandom_range(0, 1023));
        drive(1'b1, x, y, d, ys);
        if (mode == 1) begin
          drive(1'b0, x, y, int'($urandom_range(0, 1023)), ys);
        end else if (mode == 2) begin
          while ($urandom_range(0, 3) == 0) drive(1'b0, x, y, int'($urandom_range(0, 1023)), ys);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    #1;
    run_frame(7, 7, V, 0, -1, 1'b1);                          // nominal window
    run_frame(20, 20, V, 0, -1, 1'b0);                        // clamped at bottom
    run_frame(0, 0, V, 0, -1, 1'b0);                          // no mark
    run_frame(7, 7, V, 1, -1, 1'b0);                          // valid toggling
    run_frame(7, 12, 10, 0, -1, 1'b0);                        // mark changes mid-frame
    run_frame(12, 12, V, 0, -1, 1'b0);                        // picks up the new mark
    run_frame(V - YOFF, V - YOFF, V, 0, -1, 1'b0);            // window starts past last row
    run_frame(int'($urandom_range(1, V - YOFF - 1)), 0, V, 2, -1, 1'b0);
    run_frame(5, 5, V, 0, 5 + YOFF + 2, 1'b0);                // reset inside the crop
    run_frame(9, 9, V, 0, -1, 1'b0);
    run_frame(int'($urandom_range(1, V - YOFF - 1)), 3, V / 2, 2, -1, 1'b0);
    repeat (4) drive(1'b0, 0, 0, 0, 3);
    check("pending_pixels", exp_q.size(), 0);
    check("pending_no_mark", nm_q.size(), 0);
    check("frame_done_count", got_done_cnt, exp_done_cnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crop_window.md
Name: crop_window

Overview:
- Downstream consumer of the Y-start detector's oYSTART / oDVAL outputs.
- Samples the detected start row once per frame and forwards only the pixels inside a fixed-size window (rows anchored at the detected row, fixed columns) from the 640x480 10-bit pixel stream.
- Output is a compacted crop stream with in-window coordinates and an end-of-crop pulse, feeding the capture/storage stage.

Parameters:
- H_ACTIVE, 640: pixels per line; column counter wraps here.
- V_ACTIVE, 480: lines per frame; row counter wraps here.
- X_START, 160: first cropped column, inclusive.
- CROP_W, 320: cropped columns; X_START+CROP_W <= H_ACTIVE.
- Y_OFFSET, 0: rows added to the sampled Y start to give the first cropped row.
- CROP_H, 240: requested cropped rows, before clamping.

Ports:
- iCLK  in  1  system clock; all logic on its rising edge.
- iRST  in  1  asynchronous, active-low reset.
- iDVAL  in  1  pixel valid; one pixel per asserted cycle.
- iDATA  in  10  pixel value.
- iYSTART  in  16  detected start row from the detector; 0 means no mark found.
- oDVAL  out  1  crop pixel valid.
- oDATA  out  10  crop pixel value.
- oCX  out  16  column within the crop, 0..CROP_W-1.
- oCY  out  16  row within the crop, 0..rows-1.
- oFRAME_DONE  out  1  one-cycle pulse with the last crop pixel of a frame.
- oNO_MARK  out  1  one-cycle pulse at frame start when the sampled iYSTART is 0.
- oBUSY  out  1  high while the state is WAIT_WIN or CROP.

Behaviour:
- Reset (iRST low, async): all outputs 0; X/Y counters 0; latched Y0 0; state IDLE.
- Pixel counting:
  - Each cycle with iDVAL=1 advances the column counter X.
  - At X=H_ACTIVE-1, X goes to 0 and Y increments.
  - At Y=V_ACTIVE-1 with end of line, Y goes to 0.
  - Cycles with iDVAL=0 change no counter and produce no output.
  - The first iDVAL after reset is pixel (0,0).
- Frame start is a valid pixel at X=0, Y=0. At each frame start:
  - Latch Ys = iYSTART. Ys is held for the whole frame even if iYSTART changes mid-frame, so Ys is the previous frame's detection.
  - If Ys=0: pulse oNO_MARK and go to DONE.
  - Otherwise: compute Y0 = Ys + Y_OFFSET in 17 bits.
  - If Y0 >= V_ACTIVE: treat as no mark; pulse oNO_MARK, go to DONE.
  - Otherwise: Yend = min(Y0+CROP_H, V_ACTIVE) - 1 (17-bit compare), then go to WAIT_WIN.
- States:
  - IDLE: entered only from reset; frame start transitions as above.
  - WAIT_WIN: go to CROP when a valid pixel arrives with Y=Y0. Same-cycle evaluation: if Y0=0 the frame-start pixel itself is evaluated for crop.
  - CROP: a valid pixel with X in [X_START, X_START+CROP_W-1] is emitted. After the last emitted pixel (X=X_START+CROP_W-1, Y=Yend), go to DONE.
  - DONE: wait; the next frame start is handled exactly as in IDLE.
- Emission latency: exactly 1 cycle (registered).
  - oDVAL=1, oDATA=iDATA, oCX=X-X_START, oCY=Y-Y0.
  - oFRAME_DONE=1 in the same cycle as the last crop pixel.
  - oDVAL=0 on every other cycle; oDATA/oCX/oCY hold their last values.
- Reset mid-frame: returns to IDLE with counters 0; no partial oFRAME_DONE is generated.
- Clamped windows still end with oFRAME_DONE, with oCY max = Yend-Y0.

Decomposition:
- Shared package/header: H_ACTIVE, V_ACTIVE, pixel width (10), coordinate width (16), state encodings (IDLE, WAIT_WIN, CROP, DONE).
- One natural sub-module, frame_pos_counter: iDVAL-driven X/Y counter with wrap and frame-start strobe. It is reusable by the detector stage.

Test Plan:
1. Defaults, iYSTART=150 held, one full frame of iDVAL=1 with iDATA=X[9:0]:
   - Frame 2 emits 320x240 pixels, rows 150..389, columns 160..479.
   - First output oDATA=160, oCX=0, oCY=0.
   - oFRAME_DONE exactly once, with oCX=319, oCY=239.
2. iYSTART=400 at frame start:
   - Window clamps to rows 400..479 (80 rows, 25600 pixels).
   - oFRAME_DONE on oCY=79, oCX=319.
3. iYSTART=0 at frame start:
   - oNO_MARK pulses 1 cycle after pixel (0,0).
   - Zero crop pixels; oBUSY stays 0 all frame.
4. iDVAL toggled 1/0 every cycle, iYSTART=150:
   - Same 76800 outputs as test 1, each 1 cycle after its input.
   - No output on idle cycles.
5. iYSTART changed 150 -> 200 mid-frame:
   - Current frame is unaffected.
   - Next frame's first oCY=0 row is row 200.
6. iRST pulsed low during CROP (row 200):
   - All outputs 0 immediately.
   - Restarted stream: pixel (0,0) is the next frame start; no oFRAME_DONE from the aborted frame.
